// File: rtl/alu2_pkg.sv
// alu2 shared package: opcode constants and sequencer state encoding.
// Imported by alu2, alu2_seq and their benches.
package alu2_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_REGA  = 4'h1;
  localparam logic [3:0] OP_REGB  = 4'h2;
  localparam logic [3:0] OP_MULT  = 4'h3;
  localparam logic [3:0] OP_ACC   = 4'h4;
  localparam logic [3:0] OP_MSB   = 4'h5;
  localparam logic [3:0] OP_LSB   = 4'h6;
  localparam logic [3:0] OP_RESET = 4'h7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_WAIT,
    S_LDA,
    S_LDB,
    S_MUL,
    S_ACC,
    S_MSB,
    S_LSB,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/alu2_seq.sv
// alu2_seq: command sequencer feeding operand pairs into alu2 and reading
// back the 2*DATA_WIDTH accumulator as {MSB,LSB}.
// Ports: clk, a_reset_n (async, active-low), start/num_terms (run control),
// in_valid/in_ready/in_a/in_b (operand handshake), alu_opcode/alu_data/
// alu_rdata (alu2 bus), busy, result, result_valid (1-cycle pulse).
// Optional: ALU2_SEQ_ABORT_EN adds input abort (forces CLR, then IDLE).
module alu2_seq
  import alu2_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    a_reset_n,
`ifdef ALU2_SEQ_ABORT_EN
  input  logic                    abort,
`endif
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    num_terms,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic                    in_ready,
  output logic [3:0]              alu_opcode,
  output logic [DATA_WIDTH-1:0]   alu_data,
  input  logic [DATA_WIDTH-1:0]   alu_rdata,
  output logic                    busy,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic                    result_valid
);

  seq_state_t state_q, state_d;

  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [2*DATA_WIDTH-1:0] result_q;
  logic                    result_valid_q;
  logic                    abort_go;
  logic                    abort_q;

`ifdef ALU2_SEQ_ABORT_EN
  assign abort_go = abort
                 && (state_q != S_IDLE)
                 && (state_q != S_CLR);

  // Remembers that the coming CLR ends the run.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      abort_q <= 1'b0;
    end else if (abort_go) begin
      abort_q <= 1'b1;
    end else if (state_q == S_CLR) begin
      abort_q <= 1'b0;
    end
  end
`else
  assign abort_go = 1'b0;
  assign abort_q  = 1'b0;
`endif

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_CLR;
      S_CLR: begin
        if (abort_q)          state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_MSB;
        else                  state_d = S_WAIT;
      end
      S_WAIT: if (in_valid) state_d = S_LDA;
      S_LDA:  state_d = S_LDB;
      S_LDB:  state_d = S_MUL;
      S_MUL:  state_d = S_ACC;
      S_ACC: begin
        if (cnt_q == CNT_WIDTH'(1)) state_d = S_MSB;
        else                        state_d = S_WAIT;
      end
      S_MSB:  state_d = S_LSB;
      S_LSB:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_go) state_d = S_CLR;
  end

  always_comb begin
    alu_opcode = OP_NOP;
    alu_data   = '0;
    in_ready   = 1'b0;
    busy       = (state_q != S_IDLE);
    unique case (state_q)
      S_CLR:  alu_opcode = OP_RESET;
      S_WAIT: in_ready   = 1'b1;
      S_LDA: begin
        alu_opcode = OP_REGA;
        alu_data   = a_q;
      end
      S_LDB: begin
        alu_opcode = OP_REGB;
        alu_data   = b_q;
      end
      S_MUL:  alu_opcode = OP_MULT;
      S_ACC:  alu_opcode = OP_ACC;
      S_MSB:  alu_opcode = OP_MSB;
      S_LSB:  alu_opcode = OP_LSB;
      default: ;
    endcase
  end

  // alu2 data_out lags the opcode by one cycle: the MSB word is
  // on the bus during LSB, the LSB word during DONE.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      cnt_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= (state_q == S_DONE);
      if (state_q == S_IDLE && start) begin
        cnt_q <= num_terms;
      end
      if (state_q == S_ACC) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == S_WAIT && in_valid && !abort_go) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (state_q == S_LSB) begin
        result_q[2*DATA_WIDTH-1:DATA_WIDTH] <= alu_rdata;
      end
      if (state_q == S_DONE) begin
        result_q[DATA_WIDTH-1:0] <= alu_rdata;
      end
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule
